fnd_scan_driver: RTL and testbench
==================================

# fnd_scan_driver

Parametrised multiplexed seven-segment driver for the board display path, successor to the fixed 4-digit FND controller. It converts an unsigned binary value to BCD with a sequential double-dabble engine on an explicit load strobe, holds the result in a display register, and time-multiplexes DIGITS active-low digits with per-digit decimal points and overflow indication. It sits between game/score logic and the FPGA seg/an pins.

## Interface
- DIGITS, 4, number of digits driven, legal 1..8
- BIN_W, 14, width of binary_in, legal 4..32
- CLK_HZ, 100_000_000, clk frequency in Hz
- SCAN_HZ, 1000, per-digit dwell rate; TICK = CLK_HZ/SCAN_HZ clocks per digit, TICK >= 2
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- binary_in  input  BIN_W  unsigned value to display
- load  input  1  single-cycle request to convert binary_in
- dp_in  input  DIGITS  decimal point per digit, bit i = digit i, active-high
- busy  output  1  conversion in progress
- overflow  output  1  last committed value exceeded 10^DIGITS-1
- seg  output  8  active-low segments, bit7 = dp, bits6..0 = g..a
- an  output  DIGITS  active-low one-hot digit enable, bit 0 = least significant digit

## Operation
- Reset: reset is asynchronous, active-high; clock is clk. All outputs registered. Reset values: busy=0, overflow=0, seg=8'hFF, an=all ones, display register=0, digit index=0, tick counter=0, FSM=IDLE.
- FSM states IDLE, SHIFT, COMMIT.
  - IDLE: load=1 captures binary_in into shift register, clears BCD scratch (4*DIGITS bits), sets shift counter=BIN_W, computes pending overflow = (binary_in > 10^DIGITS-1); -> SHIFT.
  - SHIFT: per cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left 1; decrement counter; after BIN_W-th shift -> COMMIT. Bits shifted out of top nibble are discarded.
  - COMMIT: copy scratch to display register and pending overflow to overflow, atomically in one cycle; -> IDLE.
- busy = (state != IDLE). load while busy is ignored, not queued.
- Display register changes only in COMMIT; old value shown throughout conversion.
- Scan: tick counter counts 0..TICK-1; on wrap, digit index advances 0..DIGITS-1 and wraps to 0 (no power-of-two assumption). On the same edge seg/an update for the new index.
- Glyphs: 0-9 standard active-low patterns (0=7'h40, 1=7'h79, ... 9=7'h10); nibble codes 10-15 blank.
- overflow=1: every digit shows "-" (seg[6:0]=7'h3F), dp still honoured.
- seg[7] = ~dp_in[index], sampled at scan update.

## Timing
- load sampled in cycle 0 -> busy=1 cycles 1..BIN_W+1; display register and overflow valid from cycle BIN_W+2; busy=0 at cycle BIN_W+2, new load accepted that cycle.
- New value appears on pins at the next scan update after commit (at most TICK cycles).
- First digit lit TICK cycles after reset release: an=~1 (digit 0), then each digit dwells exactly TICK cycles; full frame = DIGITS*TICK cycles.
- reset mid-conversion: conversion aborted, display register returns to 0, outputs dark until first tick.
- Commit coinciding with scan update: scan update uses the pre-commit display value; the new value appears from the next update.

## Configuration
- FND_LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit render blank segments (seg[6:0]=7'h7F), dp still honoured; digit 0 always shown (value 0 displays "0"); ignored when overflow=1.
- Undefined: all DIGITS digits shown, including leading zeros.

## Test plan
- Reset: assert reset mid-frame -> immediately busy=0, overflow=0, seg=8'hFF, an=4'hF; first an=4'hE exactly TICK cycles after release (bench uses CLK_HZ=8, SCAN_HZ=2, TICK=4).
- Load 1234 (DIGITS=4, BIN_W=14) -> busy high 15 cycles; scan shows digit0=4 (7'h19), digit1=3, digit2=2, digit3=1; an sequence E,D,B,7 each 4 cycles.
- Load 9999 then 10000 -> first displays 9999, overflow=0; second overflow=1, all digits 7'h3F.
- Load 55 during busy from prior load of 321 -> 55 ignored, display 321, busy length unchanged.
- DIGITS=3, dp_in=3'b010, value 7 -> an cycles 6,5,3; dp low only on digit1; with FND_LEADING_ZERO_BLANK_EN digits 1,2 blank segments, without them show 0.
- Reset asserted 5 cycles into conversion of 4321 -> display 0, busy=0; after release load 8 -> displays 0008 (or 8 with blanking).

Source files
------------

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: binary-to-BCD conversion plus multiplexed active-low seven-segment scan.
// Optional feature: define FND_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module fnd_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int BIN_W   = 14,
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  binary_in,
    input  logic              load,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int TICK = CLK_HZ / SCAN_HZ;
    localparam int TW   = $clog2(TICK);
    localparam int IW   = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int CW   = $clog2(BIN_W + 1);
    localparam int BW   = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic [BW-1:0]     disp_q, disp_d;
    logic              busy_q, busy_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              wrap, blank;
    logic [3:0]        nib;
    logic [6:0]        pattern;

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

    // Double-dabble engine: capture on load, one add-3/shift step per cycle, then commit atomically.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        case (state_q)
            IDLE: if (load) begin
                bin_d   = binary_in;
                bcd_d   = '0;
                cnt_d   = CW'(BIN_W);
                pend_d  = 64'(binary_in) > MAX_VAL;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d   = {adj[BW-2:0], bin_q[BIN_W-1]};
                bin_d   = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == CW'(1) ? COMMIT : SHIFT;
            end
            COMMIT: begin
                disp_d  = bcd_q;
                ovf_d   = pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

`ifdef FND_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] zero_from;
    logic              z;
    // zero_from[i] is set when digit i and every digit above it are zero.
    always_comb begin
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z = z & (disp_q[4*i +: 4] == 4'd0);
            zero_from[i] = z;
        end
        blank = idx_q != '0 && zero_from[idx_q];
    end
`else
    assign blank = 1'b0;
`endif

    // Scan timing: each tick wrap lights the digit at idx_q, using the display value before any same-edge commit.
    always_comb begin
        wrap    = tick_q == TW'(TICK - 1);
        nib     = disp_q[4*idx_q +: 4];
        pattern = ovf_q ? 7'h3F : blank ? 7'h7F : glyph(nib);
        tick_d  = wrap ? '0 : tick_q + TW'(1);
        idx_d   = wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
        seg_d   = wrap ? {~dp_in[idx_q], pattern} : seg_q;
        an_d    = wrap ? ~(DIGITS'(1) << idx_q) : an_q;
    end

    // All state and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            tick_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed and random loads on 4-digit and 3-digit drivers, checked against an arithmetic display model.
module tb_fnd_scan_driver;
    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] bin4 = '0;
    logic        load4 = 1'b0;
    logic [3:0]  dp4 = '0;
    logic        busy4, ovf4;
    logic [7:0]  seg4;
    logic [3:0]  an4;
    logic [9:0]  bin3 = '0;
    logic        load3 = 1'b0;
    logic [2:0]  dp3 = '0;
    logic        busy3, ovf3;
    logic [7:0]  seg3;
    logic [2:0]  an3;
    int          n_pass = 0;
    int          n_total = 0;

    fnd_scan_driver #(.DIGITS(4), .BIN_W(14), .CLK_HZ(8), .SCAN_HZ(2)) u4 (
        .clk(clk), .reset(reset), .binary_in(bin4), .load(load4), .dp_in(dp4),
        .busy(busy4), .overflow(ovf4), .seg(seg4), .an(an4));

    fnd_scan_driver #(.DIGITS(3), .BIN_W(10), .CLK_HZ(8), .SCAN_HZ(2)) u3 (
        .clk(clk), .reset(reset), .binary_in(bin3), .load(load3), .dp_in(dp3),
        .busy(busy3), .overflow(ovf3), .seg(seg3), .an(an3));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int p10(input int n);
        int p = 1;
        repeat (n) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Expected pin pattern for digit i of value v on a d-digit display.
    function automatic logic [7:0] model_seg(input int v, input int d, input int i, input logic dp);
        logic ov = v > p10(d) - 1;
        logic [6:0] g = ov ? 7'h3F : digit_glyph((v / p10(i)) % 10);
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (!ov && i > 0 && v < p10(i)) g = 7'h7F;
`endif
        return {~dp, g};
    endfunction

    function automatic logic [3:0] exp_an(input bit w, input int i);
        logic [3:0] e = ~(4'b1 << i);
        if (w) e[3] = 1'b1;
        return e;
    endfunction

    function automatic logic [3:0] cur_an(input bit w);
        return w ? {1'b1, an3} : an4;
    endfunction

    function automatic logic [7:0] cur_seg(input bit w);
        return w ? seg3 : seg4;
    endfunction

    // Wait for a fresh digit-0 update, then check every digit of one frame with exact dwell.
    task automatic frame(input bit w, input int v, input logic [3:0] dp);
        int d = w ? 3 : 4;
        int n = 0;
        while ((cur_an(w) & 4'h1) == 4'h0 && n < 50) begin step(); n++; end
        while (cur_an(w) != exp_an(w, 0) && n < 100) begin step(); n++; end
        chk("frame_sync", n < 100, 1'b1);
        for (int i = 0; i < d; i++) begin
            if (i > 0) repeat (TICK) step();
            chk($sformatf("an%0d_v%0d", i, v), cur_an(w), exp_an(w, i));
            chk($sformatf("seg%0d_v%0d", i, v), cur_seg(w), model_seg(v, d, i, dp[i]));
        end
    endtask

    task automatic load_val(input bit w, input int v, input logic [3:0] dp);
        int n = 0;
        int d = w ? 3 : 4;
        if (w) begin bin3 = 10'(v); dp3 = dp[2:0]; load3 = 1'b1; end
        else begin bin4 = 14'(v); dp4 = dp; load4 = 1'b1; end
        step();
        load3 = 1'b0;
        load4 = 1'b0;
        while ((w ? busy3 : busy4) && n < 100) begin n++; step(); end
        chk($sformatf("busy_len_v%0d", v), n, w ? 11 : 15);
        chk($sformatf("ovf_v%0d", v), w ? ovf3 : ovf4, v > p10(d) - 1);
        frame(w, v, dp);
    endtask

    task automatic reset_state_check(input string tag);
        chk({tag, "_busy"}, busy4, 1'b0);
        chk({tag, "_ovf"}, ovf4, 1'b0);
        chk({tag, "_seg"}, seg4, 8'hFF);
        chk({tag, "_an"}, an4, 4'hF);
    endtask

    task automatic release_and_time(input string tag);
        int n = 0;
        step();
        reset = 1'b0;
        do begin step(); n++; end while (an4 != 4'hE && n < 20);
        chk({tag, "_first_lit"}, n, TICK);
    endtask

    initial begin
        int n;
        repeat (3) step();
        reset_state_check("por");
        release_and_time("por");

        load_val(0, 1234, 4'b0000);

        repeat (2) step();
        #2 reset = 1'b1;
        #1 reset_state_check("mid_frame");
        release_and_time("mid_frame");
        frame(0, 0, dp4);

        load_val(0, 9999, 4'b0000);
        load_val(0, 10000, 4'b0101);

        bin4 = 14'd321;
        dp4 = 4'b0000;
        load4 = 1'b1;
        step();
        n = 0;
        while (busy4 && n < 100) begin
            if (n == 3) begin bin4 = 14'd55; load4 = 1'b1; end
            else load4 = 1'b0;
            n++;
            step();
        end
        load4 = 1'b0;
        chk("busy_len_ignored_load", n, 15);
        frame(0, 321, dp4);

        load_val(1, 7, 4'b0010);

        bin4 = 14'd4321;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        repeat (4) step();
        #2 reset = 1'b1;
        #1 chk("abort_busy", busy4, 1'b0);
        release_and_time("abort");
        frame(0, 0, dp4);
        load_val(0, 8, dp4);

        repeat (6) load_val(0, $urandom_range(0, 16383), 4'($urandom));
        repeat (3) load_val(1, $urandom_range(0, 1023), 4'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
